// File: rtl/vpu_cmd_scheduler.sv
// VPU command queue and issue FSM: buffers DEX commands, issues one at a time, tracks VPU_rdy.
// Optional statistics outputs (issue_cnt, max_occ) are enabled by defining VPU_SCHED_STATS_EN.
module vpu_cmd_scheduler #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CMD_W  = 160,
  parameter int unsigned ACK_TO = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [CMD_W-1:0]       cmd_data,
  output logic                   cmd_full,
  input  logic                   flush,
  input  logic                   VPU_rdy,
  output logic                   start_VPU,
  output logic [CMD_W-1:0]       VPU_cmd,
  output logic                   busy,
`ifdef VPU_SCHED_STATS_EN
  output logic [15:0]            issue_cnt,
  output logic [$clog2(DEPTH):0] max_occ,
`endif
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ToW  = $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StAck, StRun} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [CMD_W-1:0] vpu_cmd_q, vpu_cmd_d;
  logic             overflow_q, overflow_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign cmd_full  = (count_q == CntW'(DEPTH));
  assign start_VPU = (state_q == StIssue);
  assign VPU_cmd   = vpu_cmd_q;
  assign overflow  = overflow_q;
  assign busy      = (count_q != '0) | (state_q != StIdle);

  always_comb begin
    push       = cmd_valid & ~cmd_full & ~flush;
    // Guarded so a flush on the cycle before ISSUE cannot underflow the queue.
    pop        = (state_q == StIssue) & (count_q != '0) & ~flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (cmd_valid & cmd_full);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Head is captured on the way into ISSUE so VPU_cmd is valid during the start pulse.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    vpu_cmd_d = vpu_cmd_q;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && VPU_rdy) begin
          state_d   = StIssue;
          vpu_cmd_d = mem_q[rd_ptr_q];
        end
      end
      StIssue: begin
        state_d  = StAck;
        to_cnt_d = '0;
      end
      StAck: begin
        if (!VPU_rdy) begin
          state_d = StRun;
        end else if (to_cnt_q == ToW'(ACK_TO - 1)) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (VPU_rdy) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      to_cnt_q   <= '0;
      vpu_cmd_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      to_cnt_q   <= to_cnt_d;
      vpu_cmd_q  <= vpu_cmd_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

`ifdef VPU_SCHED_STATS_EN
  logic [15:0]     issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0] max_occ_q, max_occ_d;

  assign issue_cnt = issue_cnt_q;
  assign max_occ   = max_occ_q;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 16'(start_VPU);
    max_occ_d   = (count_d > max_occ_q) ? count_d : max_occ_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      max_occ_q   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      max_occ_q   <= max_occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_cmd_scheduler.sv
// Self-checking bench for vpu_cmd_scheduler: vector table, corner-case sequences and random
// traffic against a queue-based reference model. Stats ports checked when VPU_SCHED_STATS_EN set.
module tb_vpu_cmd_scheduler;
  localparam int DEPTH  = 4;
  localparam int CMD_W  = 160;
  localparam int ACK_TO = 7;

  logic clk, rst_n, cmd_valid, flush, VPU_rdy;
  logic [CMD_W-1:0] cmd_data, VPU_cmd;
  logic cmd_full, start_VPU, busy, overflow;
`ifdef VPU_SCHED_STATS_EN
  logic [15:0] issue_cnt;
  logic [2:0]  max_occ;
`endif

  vpu_cmd_scheduler #(.DEPTH(DEPTH), .CMD_W(CMD_W), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_full(cmd_full), .flush(flush), .VPU_rdy(VPU_rdy), .start_VPU(start_VPU),
    .VPU_cmd(VPU_cmd), .busy(busy),
`ifdef VPU_SCHED_STATS_EN
    .issue_cnt(issue_cnt), .max_occ(max_occ),
`endif
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  int total = 0;
  int bad = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [CMD_W-1:0] act,
                       input logic [CMD_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic [7:0] tag);
    logic [CMD_W-1:0] r;
    r = {20{tag}};
    return r;
  endfunction

  // Reference model: a queue of pending commands plus the VPU occupancy window.
  // A started op holds the VPU until rdy has dropped and come back, or until
  // ACK_TO consecutive rdy-high cycles pass after the start without a drop.
  logic [CMD_W-1:0] mq[$];
  logic [CMD_W-1:0] m_cmd;
  bit m_start, m_occ, m_low, m_ovf;
  int m_hi, m_iss, m_max;

  task automatic model_reset();
    mq.delete();
    m_cmd = '0; m_start = 0; m_occ = 0; m_low = 0; m_ovf = 0;
    m_hi = 0; m_iss = 0; m_max = 0;
  endtask

  task automatic model_update(input bit v, input bit fl, input bit rdy,
                              input logic [CMD_W-1:0] d);
    int pre;
    bit nstart;
    pre = mq.size();
    nstart = !m_start && !m_occ && pre > 0 && rdy;
    if (nstart) m_cmd = mq[0];
    if (m_start) begin
      m_occ = 1; m_hi = 0; m_low = 0;
      m_iss = (m_iss + 1) % 65536;
    end else if (m_occ) begin
      if (m_low) begin
        if (rdy) m_occ = 0;
      end else if (!rdy) begin
        m_low = 1;
      end else begin
        m_hi++;
        if (m_hi == ACK_TO) m_occ = 0;
      end
    end
    if (v && pre == DEPTH) m_ovf = 1;
    if (fl) begin
      mq.delete();
    end else begin
      if (m_start && pre > 0) void'(mq.pop_front());
      if (v && pre < DEPTH) mq.push_back(d);
    end
    m_start = nstart;
    if (mq.size() > m_max) m_max = mq.size();
  endtask

  task automatic check_model();
    chk_b("start", start_VPU, m_start);
    chk_w("cmd", VPU_cmd, m_cmd);
    chk_b("full", cmd_full, mq.size() == DEPTH);
    chk_b("busy", busy, mq.size() != 0 || m_start || m_occ);
    chk_b("ovf", overflow, m_ovf);
`ifdef VPU_SCHED_STATS_EN
    chk_i("issue_cnt", int'(issue_cnt), m_iss);
    chk_i("max_occ", int'(max_occ), m_max);
`endif
  endtask

  task automatic step(input bit v, input bit fl, input bit rdy, input logic [CMD_W-1:0] d);
    cmd_valid = v; flush = fl; VPU_rdy = rdy; cmd_data = d;
    @(posedge clk);
    model_update(v, fl, rdy, d);
    #1;
    check_model();
  endtask

  // Reset asserted away from the clock edge; outputs must clear before any edge.
  task automatic do_reset(input bit rdy);
    rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; VPU_rdy = rdy; cmd_data = '0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_model();
  endtask

  typedef struct packed {
    bit rst; bit v; bit fl; bit rdy; logic [7:0] tag;
    bit es; bit ef; bit eb; bit eo; bit cc; logic [7:0] et;
  } vec_t;

  function automatic vec_t mkv(bit rst, bit v, bit fl, bit rdy, logic [7:0] tag,
                               bit es, bit ef, bit eb, bit eo, bit cc, logic [7:0] et);
    vec_t r;
    r = '{rst, v, fl, rdy, tag, es, ef, eb, eo, cc, et};
    return r;
  endfunction

  localparam logic [7:0] TA = 8'hA1, TB = 8'hB2, TC = 8'hC3, TD = 8'hD4;
  localparam logic [7:0] TE = 8'hE5, TF = 8'hF6;

  vec_t tv[$];
  logic [7:0] got [4];
  int scyc [4];
  int n;
  bit rdy_r;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; VPU_rdy = 1'b1; cmd_data = '0;
    model_reset();

    // Single command: start two cycles after push, busy until rdy low->high.
    tv.push_back(mkv(1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 1, TA, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 0, 0, 1, 0,  1, 0, 1, 0, 1, TA));
    tv.push_back(mkv(0, 0, 0, 1, 0,  0, 0, 1, 0, 1, TA));
    tv.push_back(mkv(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, TA));
    tv.push_back(mkv(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
    // Fill with VPU not ready, then overflow push; reset clears the sticky flag.
    tv.push_back(mkv(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TA, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TB, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TC, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TD, 0, 1, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TE, 0, 1, 1, 1, 0, 0));
    tv.push_back(mkv(0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0));
    tv.push_back(mkv(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    // Refill, release, refill to full again after the pop; no overflow expected.
    tv.push_back(mkv(0, 1, 0, 0, TA, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TB, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TC, 0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, TD, 0, 1, 1, 0, 0, 0));
    tv.push_back(mkv(0, 0, 0, 1, 0,  1, 1, 1, 0, 1, TA));
    tv.push_back(mkv(0, 0, 0, 1, 0,  0, 0, 1, 0, 1, TA));
    tv.push_back(mkv(0, 1, 0, 1, TF, 0, 1, 1, 0, 0, 0));

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset(tv[i].rdy);
      else step(tv[i].v, tv[i].fl, tv[i].rdy, mk(tv[i].tag));
      chk_b($sformatf("tbl%0d_start", i), start_VPU, tv[i].es);
      chk_b($sformatf("tbl%0d_full", i), cmd_full, tv[i].ef);
      chk_b($sformatf("tbl%0d_busy", i), busy, tv[i].eb);
      chk_b($sformatf("tbl%0d_ovf", i), overflow, tv[i].eo);
      if (tv[i].cc) chk_w($sformatf("tbl%0d_cmd", i), VPU_cmd, mk(tv[i].et));
    end

    // VPU_rdy never falls: each op times out, so starts are ISSUE + 7 ACK + IDLE apart.
    n = 0;
    for (int k = 0; k < 4; k++) begin got[k] = 8'h00; scyc[k] = 0; end
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, '0);
      if (start_VPU) begin
        if (n < 4) begin got[n] = VPU_cmd[7:0]; scyc[n] = i; end
        n++;
      end
      if (!busy) break;
    end
    chk_b("drain_busy", busy, 1'b0);
    chk_i("order_n", n, 4);
    chk_i("order0", int'(got[0]), int'(TB));
    chk_i("order1", int'(got[1]), int'(TC));
    chk_i("order2", int'(got[2]), int'(TD));
    chk_i("order3", int'(got[3]), int'(TF));
    for (int k = 1; k < 4; k++) chk_i($sformatf("gap%0d", k), scyc[k] - scyc[k-1], ACK_TO + 2);
    chk_b("no_ovf", overflow, 1'b0);

    // Flush with three queued while A runs: A completes, nothing else issues.
    do_reset(1);
    step(1, 0, 1, mk(TA));
    step(0, 0, 1, '0);
    chk_b("fl_start", start_VPU, 1'b1);
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    step(1, 0, 0, mk(TB));
    step(1, 0, 0, mk(TC));
    step(1, 0, 0, mk(TD));
    step(1, 1, 0, mk(TE));
    chk_b("fl_busy_run", busy, 1'b1);
    chk_b("fl_full", cmd_full, 1'b0);
    chk_w("fl_cmd", VPU_cmd, mk(TA));
    step(0, 0, 1, '0);
    chk_b("fl_idle", busy, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, '0);
      if (start_VPU) n++;
    end
    chk_i("fl_no_start", n, 0);
    chk_w("fl_cmd_hold", VPU_cmd, mk(TA));

    // Random traffic with occasional flushes and bursty VPU_rdy.
    do_reset(1);
    rdy_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rdy_r = ~rdy_r;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, rdy_r,
           {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
